// File: rtl/decoder1n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder1n_pkg
// Description : Shared types and helpers for the 1-to-N flit decoder leaf.
//               Holds the routing state enum and the tail-bit position.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder1n_pkg;

    // Routing state: IDLE consumes one select per packet head, LOCKED keeps
    // steering flits to the latched target until the tail flit passes.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // The tail marker is the MSB of a flit.
    function automatic int tail_pos(input int w);
        return w - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder1n_fifo.sv
`default_nettype none
// ============================================================================
// Module      : decoder1n_fifo
// Description : Per-output flit buffer, DEPTH entries, first-in-first-out.
//               Push is ignored when full, pop is ignored when empty;
//               simultaneous push and pop keeps the count unchanged.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_push, i_data - write strobe and flit
//               o_full         - count == DEPTH (registered-count based)
//               o_valid/o_data - head flit present / head flit
//               i_pop          - consumer accepts the head flit
// Revision    : 1.0 - initial release
// ============================================================================
module decoder1n_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_pop
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_push;
    logic w_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        o_valid = (r_cnt != '0);
        o_full  = (r_cnt == c_CNT_W'(DEPTH));
        o_data  = r_mem[r_rd_ptr];
        w_push  = i_push & ~o_full;
        w_pop   = i_pop & o_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only observed while o_valid is high.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder1n_leaf.sv
`default_nettype none
// ============================================================================
// Module      : decoder1n_leaf
// Description : 1-to-N flit decoder. A flit on In is steered to the output
//               channel named by S and buffered in a per-channel FIFO.
//               Selects >= N discard the flit and pulse Err for one cycle.
//               Optional packet lock: define DECODER1N_PKT_LOCK_EN to latch
//               the target on a non-tail flit and hold it until the tail flit
//               (bit W-1) passes; otherwise every flit consumes a select.
// Ports       : CLK, RESET                  - clock, sync active-high reset
//               In_data/In_valid/In_ready   - input flit stream
//               S_data/S_valid/S_ready      - output select stream
//               Out_data/Out_valid/Out_ready- N output channels, W bits each
//               Err                         - discarded-flit pulse
// Revision    : 1.0 - initial release
// ============================================================================
module decoder1n_leaf
    import decoder1n_pkg::*;
#(
    parameter  int W     = 9,
    parameter  int N     = 4,
    parameter  int DEPTH = 2,
    localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [W-1:0]   In_data,
    input  logic           In_valid,
    output logic           In_ready,
    input  logic [SW-1:0]  S_data,
    input  logic           S_valid,
    output logic           S_ready,
    output logic [N*W-1:0] Out_data,
    output logic [N-1:0]   Out_valid,
    input  logic [N-1:0]   Out_ready,
    output logic           Err
);

    localparam logic [SW:0] c_N_EXT = (SW + 1)'(N);

    logic [N-1:0]         w_full;
    logic [(1<<SW)-1:0]   w_full_pad;
    logic [N-1:0]         w_push;
    logic [SW-1:0]        w_tgt;
    logic                 w_locked;
    logic                 w_sel_ok;
    logic                 w_discard;
    logic                 w_tgt_full;
    logic                 w_in_ready;
    logic                 r_err;

    // Pad the full flags up to the select range so an out-of-range select
    // indexes a defined bit; that flit is discarded regardless.
    always_comb begin
        w_full_pad         = '1;
        w_full_pad[N-1:0]  = w_full;
    end

    always_comb begin
        w_sel_ok = ({1'b0, S_data} < c_N_EXT);
    end

`ifdef DECODER1N_PKT_LOCK_EN
    localparam int c_TAIL = tail_pos(W);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_lock_tgt;
    logic          w_tail;

    always_comb begin
        w_tail = In_data[c_TAIL];
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_lock_tgt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_in_ready && w_sel_ok && !w_tail) begin
                r_lock_tgt <= S_data;
            end
        end
    end

    // Next-state logic; a discarded head flit never locks.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_in_ready && w_sel_ok && !w_tail) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_in_ready && w_tail) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        w_locked = (r_state == ST_LOCKED);
        w_tgt    = w_locked ? r_lock_tgt : S_data;
    end
`else
    always_comb begin
        w_locked = 1'b0;
        w_tgt    = S_data;
    end
`endif

    // Handshake. Readiness depends only on registered FIFO counts, never on
    // Out_ready, so there is no combinational path from outputs to inputs.
    always_comb begin
        w_discard  = ~w_locked & ~w_sel_ok;
        w_tgt_full = w_full_pad[w_tgt];
        w_in_ready = ~RESET & In_valid &
                     (w_locked ? ~w_tgt_full
                               : (S_valid & (w_discard | ~w_tgt_full)));
        In_ready   = w_in_ready;
        S_ready    = w_in_ready & ~w_locked;
        Err        = r_err;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_in_ready & w_discard;
        end
    end

    generate
        for (genvar k = 0; k < N; k++) begin : g_chan
            always_comb begin
                w_push[k] = w_in_ready & ~w_discard & (w_tgt == SW'(k));
            end

            decoder1n_fifo #(
                .W     (W),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk     (CLK),
                .rst     (RESET),
                .i_push  (w_push[k]),
                .i_data  (In_data),
                .o_full  (w_full[k]),
                .o_valid (Out_valid[k]),
                .o_data  (Out_data[k*W +: W]),
                .i_pop   (Out_ready[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_decoder1n_leaf.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder1n_leaf
// Description : Self-checking bench for decoder1n_leaf (N=4, W=9, DEPTH=2)
//               plus a small N=3 instance for the out-of-range select case.
//               A queue-based model predicts every output each cycle;
//               directed checks pin specific hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder1n_leaf;

    localparam int W     = 9;
    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int SW    = 2;
`ifdef DECODER1N_PKT_LOCK_EN
    localparam bit c_LOCK = 1'b1;
`else
    localparam bit c_LOCK = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic [W-1:0]   In_data;
    logic           In_valid;
    logic           In_ready;
    logic [SW-1:0]  S_data;
    logic           S_valid;
    logic           S_ready;
    logic [N*W-1:0] Out_data;
    logic [N-1:0]   Out_valid;
    logic [N-1:0]   Out_ready;
    logic           Err;

    logic [W-1:0]   d3_in_data;
    logic           d3_in_valid;
    logic           d3_in_ready;
    logic [1:0]     d3_s_data;
    logic           d3_s_valid;
    logic           d3_s_ready;
    logic [3*W-1:0] d3_out_data;
    logic [2:0]     d3_out_valid;
    logic [2:0]     d3_out_ready;
    logic           d3_err;

    always #5 CLK = ~CLK;

    decoder1n_leaf #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .In_data(In_data), .In_valid(In_valid), .In_ready(In_ready),
        .S_data(S_data), .S_valid(S_valid), .S_ready(S_ready),
        .Out_data(Out_data), .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Err(Err)
    );

    decoder1n_leaf #(.W(W), .N(3), .DEPTH(DEPTH)) dut3 (
        .CLK(CLK), .RESET(RESET),
        .In_data(d3_in_data), .In_valid(d3_in_valid), .In_ready(d3_in_ready),
        .S_data(d3_s_data), .S_valid(d3_s_valid), .S_ready(d3_s_ready),
        .Out_data(d3_out_data), .Out_valid(d3_out_valid), .Out_ready(d3_out_ready),
        .Err(d3_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int s_cnt   = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one queue per channel, plus packet lock state.
    // ------------------------------------------------------------------
    logic [W-1:0] mq [N][$];
    bit           m_err    = 1'b0;
    bit           m_locked = 1'b0;
    int           m_lt     = 0;

    function automatic bit m_in_ready();
        if (RESET || !In_valid) return 1'b0;
        if (m_locked) return (mq[m_lt].size() < DEPTH);
        if (!S_valid) return 1'b0;
        if (int'(S_data) >= N) return 1'b1;
        return (mq[int'(S_data)].size() < DEPTH);
    endfunction

    always @(posedge CLK) begin
        bit fire;
        int tgt;
        if (RESET) begin
            for (int k = 0; k < N; k++) mq[k].delete();
            m_err    = 1'b0;
            m_locked = 1'b0;
        end else begin
            fire = m_in_ready();
            tgt  = m_locked ? m_lt : int'(S_data);
            for (int k = 0; k < N; k++) begin
                if (Out_ready[k] && mq[k].size() > 0) void'(mq[k].pop_front());
            end
            m_err = fire && (tgt >= N);
            if (fire && tgt < N) begin
                mq[tgt].push_back(In_data);
                if (c_LOCK) begin
                    if (!m_locked && !In_data[W-1]) begin
                        m_locked = 1'b1;
                        m_lt     = tgt;
                    end else if (m_locked && In_data[W-1]) begin
                        m_locked = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        logic [N-1:0] ev;
        bit           ir;
        if (chk_en) begin
            ir = m_in_ready();
            chk("in_ready", In_ready, ir);
            chk("s_ready", S_ready, ir && !m_locked);
            for (int k = 0; k < N; k++) ev[k] = (mq[k].size() > 0);
            chk("out_valid", Out_valid, ev);
            chk("err", Err, m_err);
            for (int k = 0; k < N; k++) begin
                if (ev[k]) chk("out_data", Out_data[k*W +: W], mq[k][0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int sel, input logic [W-1:0] d, output int waited);
        bit acc;
        bit sacc;
        bit ok;
        ok = 1'b0;
        waited = 0;
        S_data = SW'(sel);
        In_data = d;
        S_valid = 1'b1;
        In_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            acc  = In_ready;
            sacc = S_ready;
            step();
            if (sacc) s_cnt++;
            if (acc) ok = 1'b1;
            else waited++;
        end
        In_valid = 1'b0;
        S_valid = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        In_data = '0; In_valid = 1'b1; S_data = '0; S_valid = 1'b1; Out_ready = '1;
        d3_in_data = '0; d3_in_valid = 1'b0; d3_s_data = '0; d3_s_valid = 1'b0;
        d3_out_ready = '1;
        RESET = 1'b1;

        // Reset with valids held high: nothing may be accepted
        repeat (2) step();
        chk_en = 1'b1;
        @(negedge CLK);
        chk("rst_in_ready", In_ready, 0);
        chk("rst_out_valid", Out_valid, 0);
        step();
        RESET = 1'b0;
        In_valid = 1'b0;
        S_valid = 1'b0;
        step();

        // Single flit to channel 2, one-cycle latency
        send(2, 9'h0A5, w);
        @(negedge CLK);
        chk("r040_valid", Out_valid, 4'b0100);
        chk("r040_data", Out_data[2*W +: W], 9'h0A5);
        chk("r040_err", Err, 0);
        step();
        if (c_LOCK) send(2, 9'h100, w);
        repeat (2) step();

        // Backpressure on channel 1: two fit, third waits, order preserved
        Out_ready = 4'b1101;
        send(1, 9'h1A1, w); chk("r041_wait1", w, 0);
        send(1, 9'h1A2, w); chk("r041_wait2", w, 0);
        S_data = 2'd1; In_data = 9'h1A3; S_valid = 1'b1; In_valid = 1'b1;
        @(negedge CLK);
        chk("r041_blocked", In_ready, 0);
        chk("r041_head", Out_data[1*W +: W], 9'h1A1);
        step();
        Out_ready = 4'b1111;
        send(1, 9'h1A3, w);
        chk("r041_wait3", w, 1);
        @(negedge CLK);
        chk("r041_third", Out_data[1*W +: W], 9'h1A3);
        repeat (3) step();

        // Stalled channel 1 full, channel 3 still flows
        Out_ready = 4'b1101;
        send(1, 9'h111, w);
        send(1, 9'h112, w);
        send(3, 9'h1C3, w);
        chk("r042_wait", w, 0);
        @(negedge CLK);
        chk("r042_valid", Out_valid, 4'b1010);
        chk("r042_data", Out_data[3*W +: W], 9'h1C3);
        step();
        @(negedge CLK);
        chk("r042_after", Out_valid, 4'b0010);
        Out_ready = 4'b1111;
        repeat (3) step();

        // Three-flit packet to channel 0
        s_cnt = 0;
        send(0, 9'h001, w);
        send(0, 9'h002, w);
        send(0, 9'h103, w);
        chk("r043_selects", s_cnt, c_LOCK ? 1 : 3);
        S_data = 2'd1; In_data = 9'h1EE; S_valid = 1'b1; In_valid = 1'b1;
        @(negedge CLK);
        chk("r043_idle_sready", S_ready, 1);
        step();
        S_valid = 1'b0; In_valid = 1'b0;
        repeat (2) step();

        // Continuous push/pop on one channel
        for (int i = 0; i < 4; i++) begin
            send(2, W'(9'h140 + i), w);
            chk("stream_wait", w, 0);
        end
        repeat (2) step();

        // Reset with channel 0 full (and locked when enabled)
        Out_ready = 4'b1110;
        send(0, 9'h001, w);
        send(0, 9'h002, w);
        @(negedge CLK);
        chk("r045_full", Out_valid[0], 1);
        RESET = 1'b1;
        S_data = 2'd2; In_data = 9'h0BB; S_valid = 1'b1; In_valid = 1'b1;
        @(negedge CLK);
        chk("r045_rst_in_ready", In_ready, 0);
        step();
        RESET = 1'b0;
        @(negedge CLK);
        chk("r045_out_valid", Out_valid, 4'b0000);
        chk("r045_s_ready", S_ready, 1);
        step();
        S_valid = 1'b0; In_valid = 1'b0; Out_ready = 4'b1111;
        @(negedge CLK);
        chk("r045_new", Out_valid, 4'b0100);
        repeat (3) step();

        // N=3 instance: select 3 is out of range
        d3_s_data = 2'd3; d3_in_data = 9'h1DD; d3_s_valid = 1'b1; d3_in_valid = 1'b1;
        @(negedge CLK);
        chk("r044_in_ready", d3_in_ready, 1);
        chk("r044_s_ready", d3_s_ready, 1);
        step();
        d3_s_valid = 1'b0; d3_in_valid = 1'b0;
        @(negedge CLK);
        chk("r044_err", d3_err, 1);
        chk("r044_no_valid", d3_out_valid, 3'b000);
        step();
        @(negedge CLK);
        chk("r044_err_pulse", d3_err, 0);
        d3_s_data = 2'd2; d3_in_data = 9'h155; d3_s_valid = 1'b1; d3_in_valid = 1'b1;
        step();
        d3_s_valid = 1'b0; d3_in_valid = 1'b0;
        @(negedge CLK);
        chk("r044_route_valid", d3_out_valid, 3'b100);
        chk("r044_route_data", d3_out_data[2*W +: W], 9'h155);
        chk("r044_route_err", d3_err, 0);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
